// File: rtl/mem_burst_reader.sv
// Burst read engine with one-cycle-latency memory port and FWFT read buffer.
// Optional parity checking is enabled by defining MEM_BURST_READER_PARITY_CHECK_EN.
module mem_burst_reader #(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [15:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  output logic             write,
  output logic             read,
  output logic [15:0]      address,
  output logic [7:0]       data_in,
  input  logic [8:0]       data_out,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [7:0]       rd_data,
  output logic             rd_perr,
  output logic [7:0]       perr_count,
  output logic             busy,
  output logic             burst_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] left;
  logic [8:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             push;
  logic             pop;
  logic             room;
  logic             perr;
  logic [8:0]       word;

  assign write     = 1'b0;
  assign data_in   = 8'h00;
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Latency is one cycle, so a word lands on the edge closing its read cycle.
  assign push    = read;
  assign pop     = rd_valid & rd_ready;
  assign cnt_nxt = cnt + CW'(push) - CW'(pop);
  assign room    = cnt_nxt < CW'(FIFO_DEPTH);

`ifdef MEM_BURST_READER_PARITY_CHECK_EN
  assign perr = data_out[8] ^ (^data_out[7:0]);
`else
  logic parity_unused;
  assign parity_unused = data_out[8];
  assign perr = 1'b0;
`endif

  assign word = {perr, data_out[7:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      read       <= 1'b0;
      address    <= 16'h0000;
      left       <= '0;
      burst_done <= 1'b0;
    end else begin
      burst_done <= 1'b0;
      unique case (state)
        IDLE: begin
          read <= 1'b0;
          if (req_valid) begin
            if (req_len != '0) begin
              state   <= ISSUE;
              address <= req_addr;
              left    <= req_len;
              read    <= room;
            end else begin
              burst_done <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (read) begin
            address <= address + 16'd1;
            left    <= left - LEN_W'(1);
            if (left == LEN_W'(1)) begin
              state      <= WAIT;
              read       <= 1'b0;
              burst_done <= 1'b1;
            end else begin
              read <= room;
            end
          end else begin
            read <= room;
          end
        end
        WAIT: begin
          read  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          read  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      cnt <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= word;
  end

  assign rd_valid = (cnt != '0);
  assign rd_data  = rd_valid ? mem[rptr][7:0] : 8'h00;
  assign rd_perr  = rd_valid & mem[rptr][8];

`ifdef MEM_BURST_READER_PARITY_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr_count <= 8'h00;
    end else if (push && perr && perr_count != 8'hFF) begin
      perr_count <= perr_count + 8'd1;
    end
  end
`else
  assign perr_count = 8'h00;
`endif

endmodule

// File: tb/tb_mem_burst_reader.sv
// Directed scoreboard bench for mem_burst_reader.
// Expected words are queued as reads issue and checked as they drain.
module tb_mem_burst_reader;

  localparam int DEPTH = 4;
`ifdef MEM_BURST_READER_PARITY_CHECK_EN
  localparam int PCNT_EXP = 1;
`else
  localparam int PCNT_EXP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_addr = 16'h0000;
  logic [7:0]  req_len = 8'h00;
  logic        write;
  logic        read;
  logic [15:0] address;
  logic [7:0]  data_in;
  logic [8:0]  data_out;
  logic        rd_valid;
  logic        rd_ready = 1'b1;
  logic [7:0]  rd_data;
  logic        rd_perr;
  logic [7:0]  perr_count;
  logic        busy;
  logic        burst_done;

  int errors = 0;
  int checks = 0;
  int reads = 0;
  int occ = 0;
  int r0;
  int k;
  int n;
  logic [15:0] inj_addr = 16'h0040;
  logic [8:0]  exp_q [$];
  logic [15:0] addr_q [$];
  logic [8:0]  mw;
  logic        mp;

  always #5 clk = ~clk;

  mem_burst_reader #(.FIFO_DEPTH(DEPTH), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len),
    .write(write), .read(read), .address(address),
    .data_in(data_in), .data_out(data_out),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_perr(rd_perr),
    .perr_count(perr_count), .busy(busy),
    .burst_done(burst_done)
  );

  function automatic logic [8:0] mem_word(input logic [15:0] a,
                                          input logic [15:0] inj);
    logic [7:0] d;
    d = a[7:0] ^ a[15:8] ^ 8'h5A;
    if (a == inj) return 9'h001;
    return {^d, d};
  endfunction

  function automatic logic exp_perr(input logic [8:0] w);
`ifdef MEM_BURST_READER_PARITY_CHECK_EN
    return w[8] ^ (^w[7:0]);
`else
    return 1'b0;
`endif
  endfunction

  assign data_out = mem_word(address, inj_addr);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (read) begin
        chk("credit", 32'(occ < DEPTH), 32'd1);
        if (addr_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL stray_read: observed addr %0h expected none", address);
        end else begin
          chk("addr", 32'(address), 32'(addr_q.pop_front()));
        end
        mw = mem_word(address, inj_addr);
        mp = exp_perr(mw);
        exp_q.push_back({mp, mw[7:0]});
        reads++;
      end
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL extra_word: observed %0h expected none", rd_data);
        end else begin
          chk("data", 32'({rd_perr, rd_data}), 32'(exp_q.pop_front()));
        end
      end
      if (read) occ++;
      if (rd_valid && rd_ready) occ--;
    end
  end

  task automatic start_req(input logic [15:0] a, input int len);
    int w = 0;
    while (!req_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = len[7:0];
    for (int i = 0; i < len; i++) addr_q.push_back(a + 16'(i));
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_done(input int len, input bit timed);
    int c;
    @(negedge clk);
    c = 1;
    chk("busy_start", 32'(busy), 32'(len != 0));
    while (!burst_done && c < 300) begin
      @(negedge clk);
      c++;
    end
    chk("done_seen", 32'(burst_done), 32'd1);
    if (timed) chk("done_cycle", 32'(c), 32'(len + 1));
    @(negedge clk);
    chk("done_pulse", 32'(burst_done), 32'd0);
    chk("idle_after", 32'(req_ready), 32'd1);
  endtask

  task automatic drain();
    int c = 0;
    while ((exp_q.size() != 0 || rd_valid) && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("drained", 32'(exp_q.size()), 32'd0);
    chk("empty", 32'(rd_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_read", 32'(read), 32'd0);
    chk("rst_addr", 32'(address), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_rdata", 32'(rd_data), 32'd0);
    chk("rst_perr", 32'(rd_perr), 32'd0);
    chk("rst_pcnt", 32'(perr_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(burst_done), 32'd0);
    chk("write0", 32'(write), 32'd0);
    chk("data_in0", 32'(data_in), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    r0 = reads;
    start_req(16'h0010, 4);
    wait_done(4, 1'b1);
    chk("reads_len4", 32'(reads - r0), 32'd4);
    drain();

    start_req(16'hFFFE, 3);
    wait_done(3, 1'b1);
    drain();

    rd_ready = 1'b0;
    r0 = reads;
    start_req(16'h0100, 8);
    repeat (12) @(negedge clk);
    chk("stall_reads", 32'(reads - r0), 32'd4);
    chk("stall_busy", 32'(busy), 32'd1);
    chk("stall_valid", 32'(rd_valid), 32'd1);
    rd_ready = 1'b1;
    wait_done(8, 1'b0);
    chk("reads_len8", 32'(reads - r0), 32'd8);
    drain();

    start_req(16'h003F, 3);
    wait_done(3, 1'b1);
    drain();
    chk("perr_count", 32'(perr_count), 32'(PCNT_EXP));

    r0 = reads;
    start_req(16'h0500, 0);
    wait_done(0, 1'b1);
    chk("len0_reads", 32'(reads - r0), 32'd0);

    rd_ready = 1'b0;
    start_req(16'h0300, 2);
    wait_done(2, 1'b1);
    start_req(16'h0400, 2);
    wait_done(2, 1'b1);
    chk("b2b_valid", 32'(rd_valid), 32'd1);
    rd_ready = 1'b1;
    drain();

    start_req(16'h0200, 6);
    k = 0;
    n = 0;
    while (k < 3 && n < 50) begin
      @(negedge clk);
      n++;
      if (read) k++;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("mid_read", 32'(read), 32'd0);
    chk("mid_addr", 32'(address), 32'd0);
    chk("mid_valid", 32'(rd_valid), 32'd0);
    chk("mid_rdata", 32'(rd_data), 32'd0);
    chk("mid_perr", 32'(rd_perr), 32'd0);
    chk("mid_pcnt", 32'(perr_count), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_done", 32'(burst_done), 32'd0);
    addr_q.delete();
    exp_q.delete();
    occ = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_ready", 32'(req_ready), 32'd1);
    chk("post_valid", 32'(rd_valid), 32'd0);
    start_req(16'h0600, 2);
    wait_done(2, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
